pipe_stage_skid_reg: RTL
========================

Name: pipe_stage_skid_reg

Overview:
- Parametrised, elastic successor to the fixed ID→EX stage register.
- Carries one generic payload bus and one control bus between any two pipeline stages.
- Adds a valid/ready handshake and a 2-entry skid buffer, so the upstream ready path is registered.
- Keeps the existing flush (bubble insertion) and freeze (hazard stall) semantics.

Parameters:
- DATA_W, 64: payload width (operand values, PC, immediates, packed by the instantiating stage).
- CTRL_W, 16: control-bit width (WB_EN, MEM_R/W_EN, S, B, ALU_CMD...); always cleared on flush/reset.
- ZERO_DATA_ON_FLUSH, 1: 1 = data entries cleared to 0 on flush; 0 = data entries retain their value, only valid/ctrl cleared.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held entries
- freeze  in  1  stall: no accept, no emit, state held
- in_valid  in  1  upstream entry valid
- in_ready  out  1  block can accept: ~skid_valid & ~freeze
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bits
- out_valid  out  1  main_valid & ~freeze
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  main-entry payload
- out_ctrl  out  CTRL_W  main-entry control; 0 whenever main entry invalid
- occupancy  out  2  entries held: 0, 1 or 2

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each holding valid, data and ctrl.
- Reset (async): both valids = 0; data = 0; ctrl = 0; occupancy = 0. in_ready = 1 once rst deasserts, provided freeze = 0.
- Handshakes: acc = in_valid & in_ready; emit = out_valid & out_ready. Both require freeze = 0.
- Latency: 1 cycle. An entry accepted at edge N is visible on out_* after edge N when the main entry was empty or was emitted in the same cycle.
- States (occupancy):
  - EMPTY: acc → ONE (in loads main).
  - ONE:
    - acc & emit → ONE (in loads main).
    - acc & ~emit → FULL (in loads skid).
    - ~acc & emit → EMPTY.
  - FULL (in_ready = 0):
    - emit → ONE (skid moves to main, skid cleared).
    - otherwise hold.
- Ordering: strict FIFO; no entry is dropped or duplicated except by flush.
- Freeze (freeze = 1, flush = 0): all registers hold; in_ready = 0 and out_valid = 0, combinationally masked.
- Flush: priority is rst > flush > freeze > normal.
  - At the edge, both valids → 0 and ctrl → 0; data → 0 when ZERO_DATA_ON_FLUSH = 1.
  - An input presented in the flush cycle is discarded even if in_valid = 1.
  - The upstream side must not treat that cycle as accepted: in_ready is unaffected by flush, so upstream also flushes.
- Simultaneous flush & freeze: flush wins.
- Reset mid-operation: all entries lost immediately (asynchronous).
- out_ctrl is forced to 0 while the main entry is invalid. Downstream write-enables are therefore never asserted by a bubble.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined, adds two outputs, each 16-bit saturating at 16'hFFFF and cleared by rst:
  - stall_cnt: increments each cycle with freeze = 1 or (out_valid & ~out_ready).
  - flush_cnt: increments each cycle flush = 1 while occupancy != 0.
- When undefined, these ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
- Reset then idle: assert rst mid-stream with 2 entries held → out_valid = 0, out_ctrl = 0, occupancy = 0, in_ready = 1 after release.
- Streaming: out_ready = 1, push 0x11, 0x22, 0x33 on consecutive cycles → each appears 1 cycle later, occupancy stays 1, in_ready never drops.
- Backpressure: out_ready = 0, push 0xA, 0xB → occupancy = 2, in_ready = 0, 0xC held upstream. Then out_ready = 1 → outputs 0xA, 0xB, 0xC in order, nothing lost.
- Freeze: with 0xA in main and 0xB in skid, freeze for 3 cycles → out_valid = 0, in_ready = 0, state unchanged. Release → 0xA emitted next.
- Flush: occupancy = 2 and in_valid = 1 with 0xD, assert flush (with freeze = 1 too) → next cycle occupancy = 0, out_ctrl = 0, data = 0 (ZERO_DATA_ON_FLUSH = 1), 0xD never emitted.
- PIPE_STAGE_PERF_EN: apply 5 freeze cycles, then 2 flushes while non-empty → stall_cnt = 5, flush_cnt = 2. Force 70000 stall cycles → stall_cnt = 16'hFFFF.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_reg
//
// An elastic pipeline stage register with a valid/ready handshake. It carries
// one payload bus and one control bus between two pipeline stages. It holds a
// main entry, which drives the outputs, and a skid entry, which catches the
// beat that arrives while the downstream stage is stalling. Because of the
// skid entry, in_ready_o depends only on registered state and on freeze_i.
//
// Flush inserts a bubble: every held entry is killed and its control bits are
// cleared. Freeze holds every register and masks both handshakes.
//
// Parameters:
//   DATA_W             payload width
//   CTRL_W             control-bit width (cleared on flush and reset)
//   ZERO_DATA_ON_FLUSH 1: payload cleared on flush, 0: payload kept
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous, active-high reset
//   flush_i      synchronous kill of all held entries
//   freeze_i     stall: no accept, no emit, state held
//   in_valid_i   upstream entry valid
//   in_ready_o   block can accept (no skid entry held and not frozen)
//   in_data_i    upstream payload
//   in_ctrl_i    upstream control bits
//   out_valid_o  main entry valid and not frozen
//   out_ready_i  downstream accepts
//   out_data_o   main-entry payload
//   out_ctrl_o   main-entry control, 0 while the main entry is invalid
//   occupancy_o  number of entries held (0, 1 or 2)
//
// Optional feature (macro PIPE_STAGE_PERF_EN):
//   stall_cnt_o  16-bit saturating count of freeze or downstream-stall cycles
//   flush_cnt_o  16-bit saturating count of flushes that killed entries
// ---------------------------------------------------------------------------
module pipe_stage_skid_reg #(
    parameter int unsigned DATA_W             = 64,
    parameter int unsigned CTRL_W             = 16,
    parameter bit          ZERO_DATA_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              freeze_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
`ifdef PIPE_STAGE_PERF_EN
    output logic [15:0]       stall_cnt_o,
    output logic [15:0]       flush_cnt_o,
`endif
    output logic [1:0]        occupancy_o
);

    // The state encoding is the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occState_t;

    occState_t         state_q, state_d;
    logic [DATA_W-1:0] mainData_q, mainData_d;
    logic [CTRL_W-1:0] mainCtrl_q, mainCtrl_d;
    logic [DATA_W-1:0] skidData_q, skidData_d;
    logic [CTRL_W-1:0] skidCtrl_q, skidCtrl_d;

    logic mainValid;
    logic skidValid;
    logic acc;
    logic emit;

    // The valid bits follow from the occupancy state. Freeze masks both
    // handshakes, so a frozen cycle never moves an entry.
    always_comb begin
        mainValid   = (state_q != EMPTY);
        skidValid   = (state_q == FULL);
        in_ready_o  = ~skidValid & ~freeze_i;
        out_valid_o = mainValid & ~freeze_i;
        acc         = in_valid_i & in_ready_o;
        emit        = out_valid_o & out_ready_i;
        out_data_o  = mainData_q;
        out_ctrl_o  = mainValid ? mainCtrl_q : '0;
        occupancy_o = state_q;
    end

    // State and entry storage. Reset kills both entries immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            mainData_q <= '0;
            mainCtrl_q <= '0;
            skidData_q <= '0;
            skidCtrl_q <= '0;
        end else begin
            state_q    <= state_d;
            mainData_q <= mainData_d;
            mainCtrl_q <= mainCtrl_d;
            skidData_q <= skidData_d;
            skidCtrl_q <= skidCtrl_d;
        end
    end

    // Next-state and entry movement. Flush takes priority over everything
    // else and discards any beat presented in the same cycle. A freeze needs
    // no branch of its own: with acc and emit both low, every case holds.
    always_comb begin
        state_d    = state_q;
        mainData_d = mainData_q;
        mainCtrl_d = mainCtrl_q;
        skidData_d = skidData_q;
        skidCtrl_d = skidCtrl_q;

        if (flush_i) begin
            state_d    = EMPTY;
            mainCtrl_d = '0;
            skidCtrl_d = '0;
            if (ZERO_DATA_ON_FLUSH) begin
                mainData_d = '0;
                skidData_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d    = ONE;
                        mainData_d = in_data_i;
                        mainCtrl_d = in_ctrl_i;
                    end
                end
                ONE: begin
                    if (acc && emit) begin
                        mainData_d = in_data_i;
                        mainCtrl_d = in_ctrl_i;
                    end else if (acc) begin
                        state_d    = FULL;
                        skidData_d = in_data_i;
                        skidCtrl_d = in_ctrl_i;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // The skid entry is older than anything upstream, so it
                    // refills the main entry before in_ready_o rises again.
                    if (emit) begin
                        state_d    = ONE;
                        mainData_d = skidData_q;
                        mainCtrl_d = skidCtrl_q;
                        skidCtrl_d = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] stallCnt_q, stallCnt_d;
    logic [15:0] flushCnt_q, flushCnt_d;

    // Both counters saturate, so a long freeze cannot wrap back to a small
    // value.
    always_comb begin
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if ((freeze_i || (out_valid_o && !out_ready_i)) && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
        if (flush_i && (state_q != EMPTY) && (flushCnt_q != 16'hFFFF)) begin
            flushCnt_d = flushCnt_q + 16'd1;
        end
    end

    // Counter registers, cleared together with the datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign stall_cnt_o = stallCnt_q;
    assign flush_cnt_o = flushCnt_q;
`endif

endmodule
